nac_axi_arbiter: RTL and testbench
==================================

# nac_axi_arbiter

Two-master, one-slave AXI4 arbiter between the SD loader (master 0) and the NAC processor core (master 1) on one side and the MIG AXI slave port on the other. Write and read paths are arbitrated independently; a grant is held for the whole transaction, from the address handshake to the last response beat. It checks write-burst length against `awlen` and reports mismatches. It replaces the combinational loader/core mux in the standalone Artix system.

## Interface
Parameters:
- `ADDR_W`, default 32: AXI address width.
- `DATA_W`, default 32: AXI data width. `wstrb` width is `DATA_W/8`.

Ports:
- `clk`  in  1  ui_clk domain; all logic is rising-edge.
- `rst`  in  1  Synchronous, active-high reset.
- `m0_excl`  in  1  While high, master 1 is never granted; in-flight master-1 bursts complete first.
- `mN_aw{addr,len,size,burst,valid}`  in  ADDR_W/8/3/2/1  Write address from master N (N=0,1).
- `mN_awready`  out  1  Write address ready to master N.
- `mN_w{data,strb,last,valid}`  in  DATA_W/DATA_W/8/1/1  Write data from master N.
- `mN_wready`  out  1  Write data ready to master N.
- `mN_bresp`, `mN_bvalid`  out  2/1  Write response to master N.
- `mN_bready`  in  1  Write response ready from master N.
- `mN_ar{addr,len,size,burst,valid}`  in  ADDR_W/8/3/2/1  Read address from master N.
- `mN_arready`  out  1  Read address ready to master N.
- `mN_r{data,resp,last,valid}`  out  DATA_W/2/1/1  Read data to master N.
- `mN_rready`  in  1  Read data ready from master N.
- `s_aw*`, `s_w*`, `s_ar*`, `s_bready`, `s_rready`  out  as above  Outputs to the MIG slave.
- `s_awready`, `s_wready`, `s_b*`, `s_arready`, `s_r*`  in  as above  Inputs from the MIG slave.
- `wr_owner`, `rd_owner`  out  1  Current or most recent grant on each path (0 = master 0).
- `err_wlen`  out  1  Sticky: a write burst's beat count did not equal `awlen+1`.

## Operation
- **Write FSM states:** W_IDLE, W_ADDR, W_DATA, W_RESP.
  - W_IDLE: if any `mN_awvalid` is eligible, register the winner into `wr_owner` and go to W_ADDR.
  - W_ADDR: forward the owner's AW channel to `s_aw*`; `s_awready` is returned only to the owner. On handshake, latch `awlen` into the beat counter and go to W_DATA.
  - W_DATA: forward the owner's W channel. On each beat handshake, increment the counter. On a beat handshake with `wlast`: if count+1 != `awlen`+1, set `err_wlen`; go to W_RESP.
  - W_RESP: forward `s_b*` to the owner and `mN_bready` to `s_bready`. On the `bvalid`/`bready` handshake, go to W_IDLE.
- **Read FSM states:** R_IDLE, R_ADDR, R_DATA.
  - R_IDLE and R_ADDR behave as on the write path.
  - R_DATA: forward `s_r*` to the owner and the owner's `rready` to `s_rready`. On a handshake with `rlast`, go to R_IDLE.
- **Non-owner outputs:** a master that is not the owner sees `awready`, `wready`, `bvalid`, `arready` and `rvalid` at 0. Its data and response buses carry the slave values unmasked.
- **Idle slave-side outputs:** `s_awvalid`, `s_wvalid`, `s_arvalid`, `s_bready` and `s_rready` are 0 in any state where that channel is not forwarded.
- **Eligibility:** master 0 is always eligible. Master 1 is eligible only if `m0_excl` = 0. `m0_excl` is sampled in the IDLE states only.
- **Priority:** fixed, master 0 over master 1 (see Configuration).
- **Independence:** the write and read paths are fully independent and may have different owners at the same time.
- **Reset mid-burst:** both FSMs return to IDLE immediately. Transactions in flight are abandoned; the system resets the slave at the same time.

## Timing
- **Reset values:** all ready/valid outputs 0; `wr_owner` = `rd_owner` = 0; `err_wlen` = 0; FSMs in IDLE; counter 0.
- **Arbitration latency:** 1 cycle. A master asserting `awvalid` in cycle T sees `s_awvalid` asserted at T+1 at the earliest.
- **Forwarding:** combinational from the registered owner, so no added latency per beat.
- **Ordering:** W beats are never forwarded before the AW handshake completes.
- **Back-to-back grants:** a new grant is possible in the cycle after the B (or last R) handshake. Minimum idle between bursts is 1 cycle.
- **AXI stability:** valid and payload hold while ready is low; the owner is stable because it changes only in IDLE.

## Configuration
- `NAC_ARB_ROUND_ROBIN_EN` defined: when both masters are eligible in IDLE, the master that did not win the previous grant on that path wins. The first arbitration after reset goes to master 0.
- Macro not defined: fixed priority, master 0 always wins.
- `m0_excl` overrides both policies.

## Test plan
- **Loader burst:** `m0_excl`=1, m0 writes `awlen`=3 (4 beats) to 0x1000_0000 while m1 asserts `awvalid` -> m1 `awready` stays 0 throughout; 4 beats reach the slave; `bvalid` goes to m0 only; `err_wlen`=0.
- **Simultaneous requests:** `m0_excl`=0, m0 and m1 both assert `awvalid` in the same cycle, fixed priority -> m0 is served first, then m1 one cycle after m0's B handshake; `wr_owner` goes 0 then 1.
- **Round robin:** `NAC_ARB_ROUND_ROBIN_EN` defined, both masters continuously issue 1-beat reads -> grants alternate 0, 1, 0, 1; `rd_owner` toggles.
- **Concurrent read and write:** m1 reads `arlen`=7 while m0 writes -> both complete; 8 R beats all go to m1; no R beats reach m0.
- **Short burst:** `awlen`=3 with `wlast` on beat 2 -> `err_wlen`=1 and stays 1; the FSM still reaches W_RESP and then W_IDLE.
- **Reset mid-burst:** `rst` pulsed during beat 2 of 4 -> the next cycle shows all outputs at their reset values and both FSMs in IDLE.

Source files
------------

// File: rtl/nac_axi_arbiter.sv
// Two-master / one-slave AXI4 arbiter (SD loader = m0, NAC core = m1) in front of the MIG port.
// Define NAC_ARB_ROUND_ROBIN_EN for alternating grants on contention; default is fixed m0 priority.
module nac_axi_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                m0_excl,
   // master 0
   input  logic [ADDR_W-1:0]   m0_awaddr,
   input  logic [7:0]          m0_awlen,
   input  logic [2:0]          m0_awsize,
   input  logic [1:0]          m0_awburst,
   input  logic                m0_awvalid,
   output logic                m0_awready,
   input  logic [DATA_W-1:0]   m0_wdata,
   input  logic [DATA_W/8-1:0] m0_wstrb,
   input  logic                m0_wlast,
   input  logic                m0_wvalid,
   output logic                m0_wready,
   output logic [1:0]          m0_bresp,
   output logic                m0_bvalid,
   input  logic                m0_bready,
   input  logic [ADDR_W-1:0]   m0_araddr,
   input  logic [7:0]          m0_arlen,
   input  logic [2:0]          m0_arsize,
   input  logic [1:0]          m0_arburst,
   input  logic                m0_arvalid,
   output logic                m0_arready,
   output logic [DATA_W-1:0]   m0_rdata,
   output logic [1:0]          m0_rresp,
   output logic                m0_rlast,
   output logic                m0_rvalid,
   input  logic                m0_rready,
   // master 1
   input  logic [ADDR_W-1:0]   m1_awaddr,
   input  logic [7:0]          m1_awlen,
   input  logic [2:0]          m1_awsize,
   input  logic [1:0]          m1_awburst,
   input  logic                m1_awvalid,
   output logic                m1_awready,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wstrb,
   input  logic                m1_wlast,
   input  logic                m1_wvalid,
   output logic                m1_wready,
   output logic [1:0]          m1_bresp,
   output logic                m1_bvalid,
   input  logic                m1_bready,
   input  logic [ADDR_W-1:0]   m1_araddr,
   input  logic [7:0]          m1_arlen,
   input  logic [2:0]          m1_arsize,
   input  logic [1:0]          m1_arburst,
   input  logic                m1_arvalid,
   output logic                m1_arready,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic [1:0]          m1_rresp,
   output logic                m1_rlast,
   output logic                m1_rvalid,
   input  logic                m1_rready,
   // slave (MIG)
   output logic [ADDR_W-1:0]   s_awaddr,
   output logic [7:0]          s_awlen,
   output logic [2:0]          s_awsize,
   output logic [1:0]          s_awburst,
   output logic                s_awvalid,
   input  logic                s_awready,
   output logic [DATA_W-1:0]   s_wdata,
   output logic [DATA_W/8-1:0] s_wstrb,
   output logic                s_wlast,
   output logic                s_wvalid,
   input  logic                s_wready,
   input  logic [1:0]          s_bresp,
   input  logic                s_bvalid,
   output logic                s_bready,
   output logic [ADDR_W-1:0]   s_araddr,
   output logic [7:0]          s_arlen,
   output logic [2:0]          s_arsize,
   output logic [1:0]          s_arburst,
   output logic                s_arvalid,
   input  logic                s_arready,
   input  logic [DATA_W-1:0]   s_rdata,
   input  logic [1:0]          s_rresp,
   input  logic                s_rlast,
   input  logic                s_rvalid,
   output logic                s_rready,
   // status
   output logic                wr_owner,
   output logic                rd_owner,
   output logic                err_wlen
);

   localparam int unsigned CNT_W = 9;

   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

   wr_state_t        wr_state, wr_state_d;
   rd_state_t        rd_state, rd_state_d;
   logic             wr_owner_d, rd_owner_d;
   logic [CNT_W-1:0] wr_cnt, wr_cnt_d;
   logic [7:0]       wr_len, wr_len_d;
   logic             err_d;

   logic wr_req0, wr_req1, wr_pick;
   logic rd_req0, rd_req1, rd_pick;

   logic own_awvalid, own_wvalid, own_wlast, own_bready;
   logic own_arvalid, own_rready;
   logic [7:0] own_awlen;

   // Master 1 is held off entirely while the loader claims exclusivity.
   assign wr_req0 = m0_awvalid;
   assign wr_req1 = m1_awvalid & ~m0_excl;
   assign rd_req0 = m0_arvalid;
   assign rd_req1 = m1_arvalid & ~m0_excl;

`ifdef NAC_ARB_ROUND_ROBIN_EN
   logic wr_prev, rd_prev;

   // prev resets to 1 so the first contended grant after reset goes to master 0
   assign wr_pick = (wr_req0 & wr_req1) ? ~wr_prev : ~wr_req0;
   assign rd_pick = (rd_req0 & rd_req1) ? ~rd_prev : ~rd_req0;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_prev <= 1'b1;
         rd_prev <= 1'b1;
      end else begin
         if (wr_state == W_IDLE && (wr_req0 | wr_req1)) wr_prev <= wr_pick;
         if (rd_state == R_IDLE && (rd_req0 | rd_req1)) rd_prev <= rd_pick;
      end
   end
`else
   assign wr_pick = ~wr_req0;
   assign rd_pick = ~rd_req0;
`endif

   // Request payloads follow the registered owner; it only changes in IDLE.
   assign own_awvalid = wr_owner ? m1_awvalid : m0_awvalid;
   assign own_awlen   = wr_owner ? m1_awlen   : m0_awlen;
   assign own_wvalid  = wr_owner ? m1_wvalid  : m0_wvalid;
   assign own_wlast   = wr_owner ? m1_wlast   : m0_wlast;
   assign own_bready  = wr_owner ? m1_bready  : m0_bready;
   assign own_arvalid = rd_owner ? m1_arvalid : m0_arvalid;
   assign own_rready  = rd_owner ? m1_rready  : m0_rready;

   assign s_awaddr  = wr_owner ? m1_awaddr  : m0_awaddr;
   assign s_awlen   = own_awlen;
   assign s_awsize  = wr_owner ? m1_awsize  : m0_awsize;
   assign s_awburst = wr_owner ? m1_awburst : m0_awburst;
   assign s_wdata   = wr_owner ? m1_wdata   : m0_wdata;
   assign s_wstrb   = wr_owner ? m1_wstrb   : m0_wstrb;
   assign s_wlast   = own_wlast;
   assign s_araddr  = rd_owner ? m1_araddr  : m0_araddr;
   assign s_arlen   = rd_owner ? m1_arlen   : m0_arlen;
   assign s_arsize  = rd_owner ? m1_arsize  : m0_arsize;
   assign s_arburst = rd_owner ? m1_arburst : m0_arburst;

   // Response/data buses are broadcast; only the valids are qualified by owner.
   assign m0_bresp = s_bresp;
   assign m1_bresp = s_bresp;
   assign m0_rdata = s_rdata;
   assign m1_rdata = s_rdata;
   assign m0_rresp = s_rresp;
   assign m1_rresp = s_rresp;
   assign m0_rlast = s_rlast;
   assign m1_rlast = s_rlast;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state <= W_IDLE;
         rd_state <= R_IDLE;
         wr_owner <= 1'b0;
         rd_owner <= 1'b0;
         wr_cnt   <= '0;
         wr_len   <= '0;
         err_wlen <= 1'b0;
      end else begin
         wr_state <= wr_state_d;
         rd_state <= rd_state_d;
         wr_owner <= wr_owner_d;
         rd_owner <= rd_owner_d;
         wr_cnt   <= wr_cnt_d;
         wr_len   <= wr_len_d;
         err_wlen <= err_d;
      end
   end

   // Write path: next state, beat counting and channel forwarding.
   always_comb begin
      wr_state_d = wr_state;
      wr_owner_d = wr_owner;
      wr_cnt_d   = wr_cnt;
      wr_len_d   = wr_len;
      err_d      = err_wlen;
      s_awvalid  = 1'b0;
      s_wvalid   = 1'b0;
      s_bready   = 1'b0;
      m0_awready = 1'b0;
      m1_awready = 1'b0;
      m0_wready  = 1'b0;
      m1_wready  = 1'b0;
      m0_bvalid  = 1'b0;
      m1_bvalid  = 1'b0;
      case (wr_state)
         W_IDLE: begin
            if (wr_req0 | wr_req1) begin
               wr_owner_d = wr_pick;
               wr_state_d = W_ADDR;
            end
         end
         W_ADDR: begin
            s_awvalid  = own_awvalid;
            m0_awready = s_awready & ~wr_owner;
            m1_awready = s_awready &  wr_owner;
            if (own_awvalid && s_awready) begin
               wr_len_d   = own_awlen;
               wr_cnt_d   = '0;
               wr_state_d = W_DATA;
            end
         end
         W_DATA: begin
            s_wvalid  = own_wvalid;
            m0_wready = s_wready & ~wr_owner;
            m1_wready = s_wready &  wr_owner;
            if (own_wvalid && s_wready) begin
               wr_cnt_d = wr_cnt + CNT_W'(1);
               if (own_wlast) begin
                  // beats seen = wr_cnt+1 must equal awlen+1
                  if (wr_cnt != CNT_W'(wr_len)) err_d = 1'b1;
                  wr_state_d = W_RESP;
               end
            end
         end
         W_RESP: begin
            s_bready  = own_bready;
            m0_bvalid = s_bvalid & ~wr_owner;
            m1_bvalid = s_bvalid &  wr_owner;
            if (s_bvalid && own_bready) wr_state_d = W_IDLE;
         end
         default: wr_state_d = W_IDLE;
      endcase
   end

   // Read path: next state and channel forwarding.
   always_comb begin
      rd_state_d = rd_state;
      rd_owner_d = rd_owner;
      s_arvalid  = 1'b0;
      s_rready   = 1'b0;
      m0_arready = 1'b0;
      m1_arready = 1'b0;
      m0_rvalid  = 1'b0;
      m1_rvalid  = 1'b0;
      case (rd_state)
         R_IDLE: begin
            if (rd_req0 | rd_req1) begin
               rd_owner_d = rd_pick;
               rd_state_d = R_ADDR;
            end
         end
         R_ADDR: begin
            s_arvalid  = own_arvalid;
            m0_arready = s_arready & ~rd_owner;
            m1_arready = s_arready &  rd_owner;
            if (own_arvalid && s_arready) rd_state_d = R_DATA;
         end
         R_DATA: begin
            s_rready  = own_rready;
            m0_rvalid = s_rvalid & ~rd_owner;
            m1_rvalid = s_rvalid &  rd_owner;
            if (s_rvalid && own_rready && s_rlast) rd_state_d = R_IDLE;
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

endmodule

// File: tb/tb_nac_axi_arbiter.sv
// Directed bench for nac_axi_arbiter: write-path vector table plus read, round-robin and reset sequences.
// Expectations for contended reads depend on NAC_ARB_ROUND_ROBIN_EN.
module tb_nac_axi_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned NW = 25;
   localparam logic [31:0] M0_WADDR = 32'h1000_0000;
   localparam logic [31:0] M1_WADDR = 32'h2000_0040;
   localparam logic [31:0] M0_RADDR = 32'h4000_0000;
   localparam logic [31:0] M1_RADDR = 32'h3000_0100;

   logic clk = 1'b0;
   logic rst, m0_excl;
   logic [AW-1:0] m0_awaddr, m1_awaddr, m0_araddr, m1_araddr, s_awaddr, s_araddr;
   logic [7:0] m0_awlen, m1_awlen, m0_arlen, m1_arlen, s_awlen, s_arlen;
   logic [2:0] m0_awsize, m1_awsize, m0_arsize, m1_arsize, s_awsize, s_arsize;
   logic [1:0] m0_awburst, m1_awburst, m0_arburst, m1_arburst, s_awburst, s_arburst;
   logic m0_awvalid, m1_awvalid, m0_awready, m1_awready, s_awvalid, s_awready;
   logic [DW-1:0] m0_wdata, m1_wdata, s_wdata, m0_rdata, m1_rdata, s_rdata;
   logic [DW/8-1:0] m0_wstrb, m1_wstrb, s_wstrb;
   logic m0_wlast, m1_wlast, s_wlast, m0_wvalid, m1_wvalid, s_wvalid;
   logic m0_wready, m1_wready, s_wready;
   logic [1:0] m0_bresp, m1_bresp, s_bresp, m0_rresp, m1_rresp, s_rresp;
   logic m0_bvalid, m1_bvalid, s_bvalid, m0_bready, m1_bready, s_bready;
   logic m0_arvalid, m1_arvalid, s_arvalid, m0_arready, m1_arready, s_arready;
   logic m0_rlast, m1_rlast, s_rlast, m0_rvalid, m1_rvalid, s_rvalid;
   logic m0_rready, m1_rready, s_rready;
   logic wr_owner, rd_owner, err_wlen;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [11:0] in;   // excl m0_awv m1_awv m0_wv m0_wl m1_wv m1_wl s_awr s_wr s_bv m0_br m1_br
      logic [10:0] exp;  // s_awv s_wv s_br m0_awr m1_awr m0_wr m1_wr m0_bv m1_bv wr_owner err_wlen
   } wvec_t;

   wvec_t wtab[NW];

   always #5 clk = ~clk;

   nac_axi_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .m0_excl(m0_excl),
      .m0_awaddr(m0_awaddr), .m0_awlen(m0_awlen), .m0_awsize(m0_awsize), .m0_awburst(m0_awburst),
      .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
      .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
      .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
      .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
      .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
      .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
      .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen), .m1_awsize(m1_awsize), .m1_awburst(m1_awburst),
      .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
      .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
      .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
      .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
      .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
      .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
      .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
      .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
      .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .wr_owner(wr_owner), .rd_owner(rd_owner), .err_wlen(err_wlen)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [17:0] status_vec();
      return {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready,
              m0_awready, m1_awready, m0_wready, m1_wready, m0_bvalid, m1_bvalid,
              m0_arready, m1_arready, m0_rvalid, m1_rvalid, wr_owner, rd_owner, err_wlen};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic exp_own;
      int   waited;

      rst = 1'b1; m0_excl = 1'b0;
      m0_awaddr = M0_WADDR; m0_awlen = 8'd3; m0_awsize = 3'd2; m0_awburst = 2'd1; m0_awvalid = 1'b0;
      m1_awaddr = M1_WADDR; m1_awlen = 8'd0; m1_awsize = 3'd2; m1_awburst = 2'd1; m1_awvalid = 1'b0;
      m0_wdata = 32'h0BAD_F00D; m0_wstrb = 4'hF; m0_wlast = 1'b0; m0_wvalid = 1'b0; m0_bready = 1'b0;
      m1_wdata = 32'h1234_5678; m1_wstrb = 4'hF; m1_wlast = 1'b0; m1_wvalid = 1'b0; m1_bready = 1'b0;
      m0_araddr = M0_RADDR; m0_arlen = 8'd0; m0_arsize = 3'd2; m0_arburst = 2'd1; m0_arvalid = 1'b0; m0_rready = 1'b0;
      m1_araddr = M1_RADDR; m1_arlen = 8'd0; m1_arsize = 3'd2; m1_arburst = 2'd1; m1_arvalid = 1'b0; m1_rready = 1'b0;
      s_awready = 1'b0; s_wready = 1'b0; s_bresp = 2'd0; s_bvalid = 1'b0;
      s_arready = 1'b0; s_rdata = '0; s_rresp = 2'd0; s_rlast = 1'b0; s_rvalid = 1'b0;

      // loader burst (excl), m1 single beat, contended short burst, m1 after m0's B
      wtab[0]  = '{12'b1_1_1_0_0_0_0_1_1_0_0_0, 11'b0_0_0_0_0_0_0_0_0_0_0};
      wtab[1]  = '{12'b1_1_1_0_0_0_0_1_1_0_0_0, 11'b1_0_0_1_0_0_0_0_0_0_0};
      wtab[2]  = '{12'b1_0_1_1_0_0_0_1_1_0_0_0, 11'b0_1_0_0_0_1_0_0_0_0_0};
      wtab[3]  = '{12'b1_0_1_1_0_0_0_1_1_0_0_0, 11'b0_1_0_0_0_1_0_0_0_0_0};
      wtab[4]  = '{12'b1_0_1_1_0_0_0_0_0_0_0_0, 11'b0_1_0_0_0_0_0_0_0_0_0};
      wtab[5]  = '{12'b1_0_1_1_0_0_0_1_1_0_0_0, 11'b0_1_0_0_0_1_0_0_0_0_0};
      wtab[6]  = '{12'b1_0_1_1_1_0_0_1_1_0_0_0, 11'b0_1_0_0_0_1_0_0_0_0_0};
      wtab[7]  = '{12'b1_0_1_0_0_0_0_1_1_1_0_0, 11'b0_0_0_0_0_0_0_1_0_0_0};
      wtab[8]  = '{12'b1_0_1_0_0_0_0_1_1_1_1_0, 11'b0_0_1_0_0_0_0_1_0_0_0};
      wtab[9]  = '{12'b1_0_1_0_0_0_0_1_1_0_0_0, 11'b0_0_0_0_0_0_0_0_0_0_0};
      wtab[10] = '{12'b0_0_1_0_0_0_0_1_1_0_0_0, 11'b0_0_0_0_0_0_0_0_0_0_0};
      wtab[11] = '{12'b0_0_1_0_0_0_0_0_1_0_0_0, 11'b1_0_0_0_0_0_0_0_0_1_0};
      wtab[12] = '{12'b0_0_1_0_0_0_0_1_1_0_0_0, 11'b1_0_0_0_1_0_0_0_0_1_0};
      wtab[13] = '{12'b0_0_0_0_0_1_1_1_1_0_0_0, 11'b0_1_0_0_0_0_1_0_0_1_0};
      wtab[14] = '{12'b0_0_0_0_0_0_0_1_1_1_0_1, 11'b0_0_1_0_0_0_0_0_1_1_0};
      wtab[15] = '{12'b0_1_1_0_0_0_0_1_1_0_0_0, 11'b0_0_0_0_0_0_0_0_0_1_0};
      wtab[16] = '{12'b0_1_1_0_0_0_0_1_1_0_0_0, 11'b1_0_0_1_0_0_0_0_0_0_0};
      wtab[17] = '{12'b0_0_1_1_0_0_0_1_1_0_0_0, 11'b0_1_0_0_0_1_0_0_0_0_0};
      wtab[18] = '{12'b0_0_1_1_1_0_0_1_1_0_0_0, 11'b0_1_0_0_0_1_0_0_0_0_0};
      wtab[19] = '{12'b0_0_1_0_0_0_0_1_1_1_1_0, 11'b0_0_1_0_0_0_0_1_0_0_1};
      wtab[20] = '{12'b0_0_1_0_0_0_0_1_1_0_0_0, 11'b0_0_0_0_0_0_0_0_0_0_1};
      wtab[21] = '{12'b0_0_1_0_0_0_0_1_1_0_0_0, 11'b1_0_0_0_1_0_0_0_0_1_1};
      wtab[22] = '{12'b0_0_0_0_0_1_1_1_1_0_0_0, 11'b0_1_0_0_0_0_1_0_0_1_1};
      wtab[23] = '{12'b0_0_0_0_0_0_0_1_1_1_0_1, 11'b0_0_1_0_0_0_0_0_1_1_1};
      wtab[24] = '{12'b0_0_0_0_0_0_0_1_1_0_0_0, 11'b0_0_0_0_0_0_0_0_0_1_1};

      step(); step();
      rst = 1'b0;
      #3;
      chk("reset_state", 64'(status_vec()), 64'd0);
      step();

      // write-path vectors
      for (int i = 0; i < int'(NW); i++) begin
         {m0_excl, m0_awvalid, m1_awvalid, m0_wvalid, m0_wlast, m1_wvalid, m1_wlast,
          s_awready, s_wready, s_bvalid, m0_bready, m1_bready} = wtab[i].in;
         #3;
         chk($sformatf("wr_vec%0d", i),
             64'({s_awvalid, s_wvalid, s_bready, m0_awready, m1_awready, m0_wready, m1_wready,
                  m0_bvalid, m1_bvalid, wr_owner, err_wlen}), 64'(wtab[i].exp));
         if (wtab[i].exp[10])
            chk($sformatf("wr_vec%0d_awaddr", i), 64'(s_awaddr),
                64'(wtab[i].exp[1] ? M1_WADDR : M0_WADDR));
         step();
      end

      // concurrent read (m1, 8 beats) and write (m0, 1 beat)
      m0_excl = 1'b0; m0_awlen = 8'd0; m0_awvalid = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
      m1_arlen = 8'd7; m1_arvalid = 1'b1; s_arready = 1'b1; s_bvalid = 1'b0;
      m0_wvalid = 1'b0; m0_wlast = 1'b0; m1_awvalid = 1'b0;
      #3;
      chk("conc_idle", 64'({s_awvalid, s_arvalid}), 64'd0);
      step();
      #3;
      chk("conc_addr", 64'({s_awvalid, m0_awready, s_arvalid, m1_arready, m0_arready, rd_owner, wr_owner}),
          64'(7'b1_1_1_1_0_1_0));
      chk("conc_araddr", 64'(s_araddr), 64'(M1_RADDR));
      step();
      m0_awvalid = 1'b0; m1_arvalid = 1'b0; m1_rready = 1'b1; m0_rready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         m0_wvalid = (i == 0); m0_wlast = (i == 0);
         s_bvalid = (i == 1); m0_bready = (i == 1);
         s_rvalid = 1'b1; s_rdata = 32'hA500 + 32'(i); s_rlast = (i == 7);
         #3;
         chk($sformatf("conc_rbeat%0d", i), 64'({m1_rvalid, m0_rvalid, s_rready}), 64'(3'b101));
         chk($sformatf("conc_rdata%0d", i), 64'(m1_rdata), 64'(32'hA500 + 32'(i)));
         if (i == 0) chk("conc_wbeat", 64'({s_wvalid, m0_wready, m1_wready}), 64'(3'b110));
         if (i == 1) chk("conc_bresp", 64'({s_bready, m0_bvalid, m1_bvalid}), 64'(3'b110));
         step();
      end
      s_rvalid = 1'b0; s_rlast = 1'b0; s_bvalid = 1'b0; m0_bready = 1'b0;
      m0_wvalid = 1'b0; m0_wlast = 1'b0;
      #3;
      chk("conc_done", 64'({s_rready, m1_arready, m0_rvalid, m1_rvalid, rd_owner, wr_owner, err_wlen}),
          64'(7'b0_0_0_0_1_0_1));
      step();

      // both masters issue 1-beat reads continuously
      m0_arlen = 8'd0; m1_arlen = 8'd0; m0_arvalid = 1'b1; m1_arvalid = 1'b1;
      m0_rready = 1'b1; m1_rready = 1'b1;
      for (int g = 0; g < 4; g++) begin
`ifdef NAC_ARB_ROUND_ROBIN_EN
         exp_own = (g % 2) == 1;
`else
         exp_own = 1'b0;
`endif
         waited = 0;
         for (int k = 0; k < 4; k++) begin
            #3;
            if (s_arvalid) break;
            waited++;
            step();
         end
         chk($sformatf("rr_grant%0d_latency", g), 64'(waited), 64'd1);
         chk($sformatf("rr_grant%0d_owner", g), 64'(rd_owner), 64'(exp_own));
         chk($sformatf("rr_grant%0d_araddr", g), 64'(s_araddr), 64'(exp_own ? M1_RADDR : M0_RADDR));
         step();
         s_rvalid = 1'b1; s_rlast = 1'b1;
         #3;
         chk($sformatf("rr_grant%0d_rvalid", g), 64'({m0_rvalid, m1_rvalid}), 64'(exp_own ? 2'b01 : 2'b10));
         step();
         s_rvalid = 1'b0; s_rlast = 1'b0;
      end
      m0_arvalid = 1'b0; m1_arvalid = 1'b0;
      step(); step();

      // reset during beat 2 of a 4-beat write with an m1 read in flight
      m0_awlen = 8'd3; m0_awvalid = 1'b1; m1_arlen = 8'd3; m1_arvalid = 1'b1;
      step();
      step();
      m0_awvalid = 1'b0; m1_arvalid = 1'b0;
      m0_wvalid = 1'b1; m0_wlast = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b0;
      step();
      rst = 1'b1;
      #3;
      chk("rst_mid_beat2", 64'({s_wvalid, m1_rvalid, rd_owner}), 64'(3'b111));
      step();
      rst = 1'b0;
      #3;
      chk("rst_mid_state", 64'(status_vec()), 64'd0);
      m0_wvalid = 1'b0; s_rvalid = 1'b0; m0_awvalid = 1'b1;
      step();
      #3;
      chk("rst_recover", 64'({s_awvalid, m0_awready, wr_owner}), 64'(3'b110));
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
